// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating output-register mux.
package mux_pkg;

    // Channel selection policy.
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping at N-1.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned  N  = DEFAULT_N,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] sel,
    output logic          any
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [SW:0] idx;

    // Scan offsets N..1 so the smallest offset with a request wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int j = int'(N); j >= 1; j--) begin
            idx = {1'b0, ptr} + (SW + 1)'(j);
            if (idx >= (SW + 1)'(N)) begin
                idx = idx - (SW + 1)'(N);
            end
            if (req[idx[SW-1:0]]) begin
                sel = idx[SW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 mux into a single-entry output register, select- or round-robin-driven.
module arb_mux
    import mux_pkg::*;
#(
    parameter int unsigned  N    = DEFAULT_N,
    parameter int unsigned  W    = DEFAULT_W,
    parameter mode_e        MODE = MODE_SEL,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW-1:0]       s,
    input  logic [N-1:0]        in_valid,
    input  logic [N-1:0][W-1:0] in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SW-1:0]       out_ch,
    input  logic                out_ready
);

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_ch_q;

    logic          load;
    logic          grant;
    logic [SW-1:0] sel;
    logic [W-1:0]  sel_data;

    assign load = !out_valid_q || out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SW-1:0] ptr_q;
        logic          unused_s;

        assign unused_s = ^s;

        rr_pick #(
            .N (N)
        ) u_rr_pick (
            .req (in_valid),
            .ptr (ptr_q),
            .sel (sel),
            .any (grant)
        );

        // Pointer moves only on an accepted transfer; reset gives channel 0 priority.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr_q <= SW'(N - 1);
            end else if (load && grant) begin
                ptr_q <= sel;
            end
        end
    end else begin : g_sel
        // Zero-padded request vector makes selects >= N read as "no request".
        logic [(1 << SW)-1:0] valid_ext;

        // Pad in_valid up to the full select range.
        always_comb begin
            valid_ext          = '0;
            valid_ext[N-1:0]   = in_valid;
        end

        assign sel   = s;
        assign grant = valid_ext[s];
    end

    // Data mux and one-hot accept; in_ready is held low while in reset.
    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel == SW'(i)) begin
                sel_data    = in_data[i];
                in_ready[i] = rst && load && grant;
            end
        end
    end

    // Output register: load on transfer, empty when free with nothing granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (load) begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_ch_q    <= sel;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: four arb_mux configurations against a behavioural model.
module tb_arb_mux;
    import mux_pkg::*;

    // dut0: N=4 SEL, dut1: N=4 RR, dut2: N=3 RR, dut3: N=3 SEL
    localparam int NK [4] = '{4, 4, 3, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       iv   [4];
    logic [3:0][31:0] id   [4];
    logic [1:0]       sv   [4];
    logic             ordy [4];

    wire  [3:0]  ir_a, ir_b;
    wire  [2:0]  ir_c, ir_d;
    logic [3:0]  ir_w [4];
    wire         ov   [4];
    wire  [31:0] od   [4];
    wire  [1:0]  oc   [4];

    assign ir_w[0] = ir_a;
    assign ir_w[1] = ir_b;
    assign ir_w[2] = {1'b0, ir_c};
    assign ir_w[3] = {1'b0, ir_d};

    arb_mux #(.N(4), .W(32), .MODE(MODE_SEL)) u_dut0 (
        .clk(clk), .rst(rst), .s(sv[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(ir_a), .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]),
        .out_ready(ordy[0]));
    arb_mux #(.N(4), .W(32), .MODE(MODE_RR)) u_dut1 (
        .clk(clk), .rst(rst), .s(sv[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(ir_b), .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]),
        .out_ready(ordy[1]));
    arb_mux #(.N(3), .W(32), .MODE(MODE_RR)) u_dut2 (
        .clk(clk), .rst(rst), .s(sv[2]), .in_valid(iv[2][2:0]), .in_data(id[2][2:0]),
        .in_ready(ir_c), .out_valid(ov[2]), .out_data(od[2]), .out_ch(oc[2]),
        .out_ready(ordy[2]));
    arb_mux #(.N(3), .W(32), .MODE(MODE_SEL)) u_dut3 (
        .clk(clk), .rst(rst), .s(sv[3]), .in_valid(iv[3][2:0]), .in_data(id[3][2:0]),
        .in_ready(ir_d), .out_valid(ov[3]), .out_data(od[3]), .out_ch(oc[3]),
        .out_ready(ordy[3]));

    // Reference model: contents of the output register and the round-robin pointer.
    bit          mv [4];
    logic [31:0] md [4];
    int          mc [4];
    int          mp [4];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    function automatic bit is_rr(input int k);
        return (k == 1) || (k == 2);
    endfunction

    function automatic void reset_model();
        for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
            mc[k] = 0;
            mp[k] = NK[k] - 1;
        end
    endfunction

    // Which channel the rules say should be granted this cycle.
    function automatic void pick(input int k, output bit g, output int sel);
        int c;
        g   = 1'b0;
        sel = 0;
        if (is_rr(k)) begin
            for (int j = 1; j <= NK[k]; j++) begin
                c = (mp[k] + j) % NK[k];
                if (!g && iv[k][c]) begin
                    g   = 1'b1;
                    sel = c;
                end
            end
        end else begin
            sel = int'(sv[k]);
            g   = (sel < NK[k]) && iv[k][sel];
        end
    endfunction

    task automatic check(input string tag, input int k, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, k, 64'(ov[k]), 64'(mv[k]));
            check({tag, "_data"},  k, 64'(od[k]), 64'(md[k]));
            check({tag, "_ch"},    k, 64'(oc[k]), 64'(mc[k]));
        end
    endtask

    // One clock: check pre-edge accept and outputs, advance model, check post-edge.
    task automatic step();
        bit       g   [4];
        int       sel [4];
        bit       ld  [4];
        bit [3:0] er;
        #1;
        for (int k = 0; k < 4; k++) begin
            ld[k] = !mv[k] || ordy[k];
            pick(k, g[k], sel[k]);
            er = (rst && ld[k] && g[k]) ? 4'(1 << sel[k]) : 4'b0;
            check("in_ready", k, 64'(ir_w[k]), 64'(er));
        end
        check_outputs("pre");
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (!rst) begin
                mv[k] = 1'b0;
                md[k] = '0;
                mc[k] = 0;
                mp[k] = NK[k] - 1;
            end else if (ld[k]) begin
                if (g[k]) begin
                    mv[k] = 1'b1;
                    md[k] = id[k][sel[k]];
                    mc[k] = sel[k];
                    if (is_rr(k)) mp[k] = sel[k];
                end else begin
                    mv[k] = 1'b0;
                end
            end
        end
        #1;
        check_outputs("post");
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) id[k][c] = $urandom;
        end
    endtask

    int rr4 [6] = '{0, 1, 2, 3, 0, 1};
    int rr3 [3] = '{0, 2, 0};

    initial begin
        for (int k = 0; k < 4; k++) begin
            iv[k]   = 4'hF;
            sv[k]   = 2'd0;
            ordy[k] = 1'b1;
        end
        randomize_data();
        reset_model();

        // Reset asserted with every channel requesting.
        #1 rst = 1'b0;
        #1;
        check_outputs("reset");
        for (int k = 0; k < 4; k++) check("reset_ready", k, 64'(ir_w[k]), 64'd0);
        step();
        step();

        // Release reset and set up the directed scenarios per instance.
        rst     = 1'b1;
        sv[0]   = 2'd2;
        iv[0]   = 4'b0100;
        id[0][2] = 32'hDEADBEEF;
        iv[1]   = 4'b1111;
        iv[2]   = 4'b0101;
        iv[3]   = 4'b0111;
        sv[3]   = 2'd0;
        #1;
        check("baseline_ready", 0, 64'(ir_w[0]), 64'h4);
        step();
        check("baseline_valid", 0, 64'(ov[0]), 64'd1);
        check("baseline_data",  0, 64'(od[0]), 64'hDEADBEEF);
        check("baseline_ch",    0, 64'(oc[0]), 64'd2);
        check("rr4_seq", 1, 64'(oc[1]), 64'(rr4[0]));
        check("rr3_seq", 2, 64'(oc[2]), 64'(rr3[0]));

        // Out-of-range select on the N=3 instance.
        sv[3] = 2'd3;
        for (int i = 1; i < 6; i++) begin
            step();
            check("rr4_seq", 1, 64'(oc[1]), 64'(rr4[i]));
            check("rr4_gapless", 1, 64'(ov[1]), 64'd1);
            if (i < 3) check("rr3_seq", 2, 64'(oc[2]), 64'(rr3[i]));
            if (i == 1) begin
                check("oor_ready", 3, 64'(ir_w[3]), 64'd0);
                check("oor_drop",  3, 64'(ov[3]), 64'd0);
            end
        end

        // Backpressure: three stalled cycles, select wiggled, then release.
        for (int k = 0; k < 4; k++) begin
            iv[k]   = 4'hF;
            ordy[k] = 1'b0;
        end
        sv[3] = 2'd1;
        step();
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            sv[0] = 2'($urandom_range(0, 3));
            step();
        end
        for (int k = 0; k < 4; k++) ordy[k] = 1'b1;
        step();
        check("bp_release_rr", 1, 64'(ov[1]), 64'd1);

        // Reset pulsed in the middle of a stall.
        for (int k = 0; k < 4; k++) ordy[k] = 1'b0;
        step();
        #2 rst = 1'b0;
        reset_model();
        #1;
        for (int k = 0; k < 4; k++) check("async_reset_valid", k, 64'(ov[k]), 64'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) ordy[k] = 1'b1;
        step();
        check("post_reset_rr_ch", 1, 64'(oc[1]), 64'd0);
        check("post_reset_rr_ch", 2, 64'(oc[2]), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                iv[k]   = 4'($urandom);
                sv[k]   = 2'($urandom);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            randomize_data();
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
